// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg: shared constants for rom_dl_sequencer.
// Defines the ROM region map (base and size per region), the total image size and the sequencer state type.
package rom_dl_pkg;
  localparam int N_REGIONS = 4;
  localparam logic [24:0] REG_BASE [N_REGIONS] = '{25'h0000, 25'h6000, 25'h7000, 25'h9000};
  localparam logic [24:0] REG_SIZE [N_REGIONS] = '{25'h6000, 25'h1000, 25'h2000, 25'h4000};
  localparam logic [24:0] TOTAL_SIZE = 25'hD000;
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, DONE} state_e;
endpackage

// File: rtl/rom_region_decode.sv
// rom_region_decode: combinational map from a linear download address to a region hit and a region-local offset.
// Ports: addr_i linear byte address; hit_o one-hot region hit; ofs_o offset inside the hit region; oor_o address past the image.
module rom_region_decode
  import rom_dl_pkg::*;
#(
  parameter int OFS_W = 16
) (
  input  logic [24:0]          addr_i,
  output logic [N_REGIONS-1:0] hit_o,
  output logic [OFS_W-1:0]     ofs_o,
  output logic                 oor_o
);
  always_comb begin
    hit_o = '0;
    ofs_o = '0;
    for (int i = 0; i < N_REGIONS; i++)
      if (addr_i >= REG_BASE[i] && addr_i < REG_BASE[i] + REG_SIZE[i]) begin
        hit_o[i] = 1'b1;
        ofs_o = OFS_W'(addr_i - REG_BASE[i]);
      end
    oor_o = ~|hit_o;
  end
endmodule

// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: steers the HPS ROM download into region writes and holds the game core in reset until it settles.
// Optional: define ROM_CKSUM_EN to accumulate a 16-bit byte sum and flag dl_error when it differs from CKSUM_EXPECT.
// Ports: clk_sys, reset_n (sync, active-low); ioctl_download/wr/addr/dout download stream in, ioctl_wait stall out;
//   tgt_busy target backpressure; rom_we/rom_addr/rom_data region write; core_reset, dl_done, dl_error, cksum status.
module rom_dl_sequencer
  import rom_dl_pkg::*;
#(
  parameter int          HOLD_CYCLES  = 16,
  parameter int          OFS_W        = 16,
  parameter logic [15:0] CKSUM_EXPECT = 16'h0000
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ioctl_download,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  output logic                 ioctl_wait,
  input  logic                 tgt_busy,
  output logic [N_REGIONS-1:0] rom_we,
  output logic [OFS_W-1:0]     rom_addr,
  output logic [7:0]           rom_data,
  output logic                 core_reset,
  output logic                 dl_done,
  output logic                 dl_error,
  output logic [15:0]          cksum
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  state_e state_q, state_d;
  logic dl_q, pend_q, pend_d, wait_q, err_q, err_d;
  logic [24:0] paddr_q;
  logic [7:0] pdata_q;
  logic [16:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N_REGIONS-1:0] hit;
  logic oor, rise, fall, load, cap, acc, viol, fire, end_chk, bad_sum;
  rom_region_decode #(.OFS_W(OFS_W)) u_dec (.addr_i(paddr_q), .hit_o(hit), .ofs_o(rom_addr), .oor_o(oor));
  assign rise = ioctl_download & ~dl_q;
  assign fall = ~ioctl_download & dl_q;
  // the buffer frees when its byte is written, or at once when it is out of range and will never be written
  assign fire = pend_q & (~tgt_busy | oor);
  assign cap = ioctl_wr & (state_q == LOAD);
  // a byte landing in the cycle the buffer frees is accepted; only a still-blocked buffer drops it
  assign acc = cap & (~pend_q | fire);
  assign viol = cap & pend_q & ~fire;
  assign rom_we = hit & {N_REGIONS{pend_q & ~tgt_busy & reset_n}};
  assign load = (state_d == LOAD) & (state_q != LOAD);
  assign pend_d = acc | (pend_q & ~fire);
  assign cnt_d = load ? '0 : cnt_q + {16'h0, acc & ~&cnt_q};
  assign err_d = ~load & (err_q | viol | (pend_q & oor) | (end_chk & ((cnt_q != 17'(TOTAL_SIZE)) | bad_sum)));
  assign ioctl_wait = wait_q;
  assign rom_data = pdata_q;
  assign core_reset = state_q != DONE;
  assign dl_done = state_q == DONE;
  assign dl_error = err_q;
`ifdef ROM_CKSUM_EN
  localparam bit CK_EN = 1'b1;
  logic [15:0] sum_q;
  always_ff @(posedge clk_sys) sum_q <= (!reset_n || load) ? '0 : sum_q + (|rom_we ? 16'(pdata_q) : 16'h0);
  assign cksum = sum_q;
`else
  localparam bit CK_EN = 1'b0;
  assign cksum = '0;
`endif
  assign bad_sum = CK_EN & (cksum != CKSUM_EXPECT);
  always_comb begin
    state_d = state_q;
    hold_d = '0;
    end_chk = 1'b0;
    case (state_q)
      IDLE: state_d = rise ? LOAD : IDLE;
      LOAD: state_d = fall ? DRAIN : LOAD;
      DRAIN: begin
        end_chk = ~pend_q;
        state_d = pend_q ? DRAIN : HOLD;
      end
      HOLD: begin
        hold_d = hold_q + 1'b1;
        state_d = rise ? LOAD : (hold_q == HW'(HOLD_CYCLES - 1)) ? DONE : HOLD;
      end
      DONE: state_d = rise ? LOAD : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dl_q <= 1'b0;
      pend_q <= 1'b0;
      wait_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      hold_q <= '0;
      paddr_q <= '0;
      pdata_q <= '0;
    end else begin
      state_q <= state_d;
      dl_q <= ioctl_download;
      pend_q <= pend_d;
      wait_q <= pend_q & ~fire;
      err_q <= err_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      paddr_q <= acc ? ioctl_addr : paddr_q;
      pdata_q <= acc ? ioctl_dout : pdata_q;
    end
  end
endmodule

// File: tb/tb_rom_dl_sequencer.sv
// tb_rom_dl_sequencer: directed self-checking bench for rom_dl_sequencer.
module tb_rom_dl_sequencer;
  import rom_dl_pkg::*;
  logic clk_sys = 1'b0, reset_n = 1'b0, ioctl_download = 1'b0, ioctl_wr = 1'b0, tgt_busy = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0;
  logic ioctl_wait, core_reset, dl_done, dl_error;
  logic [3:0] rom_we;
  logic [15:0] rom_addr, cksum;
  logic [7:0] rom_data;
  int n_tests = 0, n_fail = 0;
  int mon_bad = 0, mon_cnt = 0;
  logic mon_en = 1'b0;
`ifdef ROM_CKSUM_EN
  localparam logic [15:0] SUM_FULL = 16'h1234, SUM_SHORT = 16'h1235;
`else
  localparam logic [15:0] SUM_FULL = 16'h0000, SUM_SHORT = 16'h0000;
`endif
  always #5 clk_sys = ~clk_sys;
  rom_dl_sequencer #(.HOLD_CYCLES(16), .OFS_W(16), .CKSUM_EXPECT(16'h1234)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .tgt_busy(tgt_busy),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data), .core_reset(core_reset),
    .dl_done(dl_done), .dl_error(dl_error), .cksum(cksum)
  );
  function automatic logic [3:0] exp_we(input int a);
    return a < 'h6000 ? 4'b0001 : a < 'h7000 ? 4'b0010 : a < 'h9000 ? 4'b0100 : 4'b1000;
  endfunction
  function automatic logic [15:0] exp_ofs(input int a);
    return 16'(a < 'h6000 ? a : a < 'h7000 ? a - 'h6000 : a < 'h9000 ? a - 'h7000 : a - 'h9000);
  endfunction
  // full-image pattern: xor of address bytes up to 0xCF00, then a tail chosen so the 16-bit sum is 0x1234
  function automatic logic [7:0] pat(input int a);
    return a < 'hCF00 ? 8'(a ^ (a >> 8)) : a < 'hCFFA ? 8'hFF : a == 'hCFFA ? 8'hAE : 8'h00;
  endfunction
  // short pattern: 18 x 0xFF + 0x47 sums to 0x1235
  function automatic logic [7:0] spat(input int a);
    return a < 18 ? 8'hFF : a == 18 ? 8'h47 : 8'h00;
  endfunction
  always @(negedge clk_sys)
    if (mon_en && rom_we != 4'b0000) begin
      if (rom_we !== exp_we(mon_cnt) || rom_addr !== exp_ofs(mon_cnt) || rom_data !== pat(mon_cnt)) mon_bad++;
      mon_cnt++;
    end
  task automatic cyc;
    @(posedge clk_sys);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (dl_done !== 1'b1 && n < 100) begin
      cyc();
      #1;
      n++;
    end
    chk(tag, 32'(dl_done), 1);
  endtask
  initial begin
    int hc;
    cyc();
    cyc();
    #1;
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_dl_done", 32'(dl_done), 0);
    chk("rst_dl_error", 32'(dl_error), 0);
    chk("rst_rom_we", 32'(rom_we), 0);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_rom_data", 32'(rom_data), 0);
    chk("rst_cksum", 32'(cksum), 0);
    reset_n = 1'b1;
    cyc(); ioctl_download = 1'b1;
    cyc();
    cyc();
    cyc(); ioctl_wr = 1'b1; ioctl_addr = 25'h6005; ioctl_dout = 8'hA5; #1;
    chk("wr_no_early_we", 32'(rom_we), 0);
    cyc(); ioctl_wr = 1'b0; #1;
    chk("wr_we", 32'(rom_we), 'b0010);
    chk("wr_addr", 32'(rom_addr), 'h0005);
    chk("wr_data", 32'(rom_data), 'hA5);
    chk("wr_no_wait", 32'(ioctl_wait), 0);
    cyc(); #1;
    chk("wr_we_single", 32'(rom_we), 0);
    cyc(); ioctl_wr = 1'b1; ioctl_dout = 8'h5A;
    cyc(); ioctl_wr = 1'b0; tgt_busy = 1'b1; #1;
    chk("stall_we_1", 32'(rom_we), 0);
    chk("stall_wait_0", 32'(ioctl_wait), 0);
    cyc(); #1;
    chk("stall_we_2", 32'(rom_we), 0);
    chk("stall_wait_1", 32'(ioctl_wait), 1);
    cyc(); #1;
    chk("stall_we_3", 32'(rom_we), 0);
    chk("stall_wait_2", 32'(ioctl_wait), 1);
    cyc(); tgt_busy = 1'b0; #1;
    chk("stall_we", 32'(rom_we), 'b0010);
    chk("stall_data", 32'(rom_data), 'h5A);
    chk("stall_wait_3", 32'(ioctl_wait), 1);
    cyc(); #1;
    chk("stall_we_once", 32'(rom_we), 0);
    chk("stall_wait_off", 32'(ioctl_wait), 0);
    chk("stall_no_err", 32'(dl_error), 0);
    cyc(); ioctl_wr = 1'b1; ioctl_addr = 25'hD000;
    cyc(); ioctl_wr = 1'b0; #1;
    chk("oor_no_we", 32'(rom_we), 0);
    cyc(); #1;
    chk("oor_no_we_2", 32'(rom_we), 0);
    chk("oor_err", 32'(dl_error), 1);
    cyc(); ioctl_wr = 1'b1; ioctl_addr = 25'h0010; ioctl_dout = 8'h77; tgt_busy = 1'b1;
    cyc(); ioctl_wr = 1'b0; reset_n = 1'b0; ioctl_download = 1'b0; #1;
    chk("mid_rst_no_we", 32'(rom_we), 0);
    cyc(); reset_n = 1'b1; tgt_busy = 1'b0; #1;
    chk("mid_rst_core_reset", 32'(core_reset), 1);
    chk("mid_rst_done", 32'(dl_done), 0);
    chk("mid_rst_err", 32'(dl_error), 0);
    chk("mid_rst_we", 32'(rom_we), 0);
    chk("mid_rst_wait", 32'(ioctl_wait), 0);
    chk("mid_rst_addr", 32'(rom_addr), 0);
    chk("mid_rst_data", 32'(rom_data), 0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    cyc(); #1;
    chk("mid_rst_discard", 32'(rom_we), 0);
    cyc(); ioctl_download = 1'b1;
    cyc();
    cyc();
    cyc(); ioctl_wr = 1'b1; ioctl_addr = 25'h0020; ioctl_dout = 8'h11; tgt_busy = 1'b1;
    cyc(); ioctl_addr = 25'h0021; ioctl_dout = 8'h22; #1;
    chk("viol_we_blocked", 32'(rom_we), 0);
    chk("viol_err_before", 32'(dl_error), 0);
    cyc(); ioctl_wr = 1'b0; tgt_busy = 1'b0; #1;
    chk("viol_err", 32'(dl_error), 1);
    chk("viol_we", 32'(rom_we), 'b0001);
    chk("viol_addr_kept", 32'(rom_addr), 'h0020);
    chk("viol_data_kept", 32'(rom_data), 'h11);
    cyc(); #1;
    chk("viol_dropped", 32'(rom_we), 0);
    cyc(); ioctl_download = 1'b0;
    wait_done("viol_done");
    chk("viol_err_end", 32'(dl_error), 1);
    cyc(); ioctl_download = 1'b1; #1;
    chk("redl_done_still", 32'(dl_done), 1);
    chk("redl_core_free", 32'(core_reset), 0);
    cyc(); #1;
    chk("redl_done_clr", 32'(dl_done), 0);
    chk("redl_core_reset", 32'(core_reset), 1);
    chk("redl_err_clr", 32'(dl_error), 0);
    mon_en = 1'b1;
    for (int a = 0; a < 'hD000; a++) begin
      cyc(); ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = pat(a);
    end
    cyc(); ioctl_wr = 1'b0; ioctl_download = 1'b0;
    hc = 0;
    for (int k = 0; k < 17; k++) begin
      cyc(); #1;
      if (core_reset === 1'b1) hc++;
    end
    chk("full_drain_hold", hc, 17);
    cyc(); #1;
    chk("full_core_free", 32'(core_reset), 0);
    chk("full_done", 32'(dl_done), 1);
    chk("full_err", 32'(dl_error), 0);
    chk("full_cksum", 32'(cksum), 32'(SUM_FULL));
    mon_en = 1'b0;
    chk("full_region_writes", mon_bad, 0);
    chk("full_write_count", mon_cnt, 'hD000);
    cyc(); ioctl_download = 1'b1;
    cyc(); #1;
    chk("short_cksum_clr", 32'(cksum), 0);
    for (int a = 0; a < 'h100; a++) begin
      cyc(); ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = spat(a);
    end
    cyc(); ioctl_wr = 1'b0; ioctl_download = 1'b0;
    wait_done("short_done");
    chk("short_err", 32'(dl_error), 1);
    chk("short_cksum", 32'(cksum), 32'(SUM_SHORT));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_dl_sequencer.md
Name: rom_dl_sequencer

Overview:
- Sequences the HPS ROM-download stream into the core's ROM regions: main CPU, sound CPU, character and sprite ROMs.
- Decodes the linear ioctl address into a one-hot region write strobe and a region-local offset.
- Buffers one write so a busy target can stall the HPS.
- Holds the game core in reset from download start until the last write has drained plus a settle period, then reports done/error.

Parameters:
- HOLD_CYCLES, 16: clk_sys cycles core_reset stays high after drain completes; minimum 1.
- OFS_W, 16: width of rom_addr (region-local offset).
- CKSUM_EXPECT, 16'h0000: expected 16-bit byte sum. Used only with ROM_CKSUM_EN.

Ports:
- clk_sys in 1: system clock, the only clock.
- reset_n in 1: synchronous, active-low reset.
- ioctl_download in 1: download window from hps_io.
- ioctl_wr in 1: one-cycle byte strobe.
- ioctl_addr in 25: linear byte address.
- ioctl_dout in 8: byte data.
- ioctl_wait out 1: stall request to hps_io.
- tgt_busy in 1: target memory cannot accept a write this cycle.
- rom_we out N_REGIONS: one-hot write strobe, one-cycle pulse.
- rom_addr out OFS_W: offset within the selected region.
- rom_data out 8: write data.
- core_reset out 1: reset to the game core.
- dl_done out 1: download finished and core released.
- dl_error out 1: sticky error for the last download.
- cksum out 16: running byte sum; driven 0 without ROM_CKSUM_EN.

Behaviour:
- Reset values (reset_n=0 at a clk_sys edge): core_reset=1, dl_done=0, dl_error=0, rom_we=0, ioctl_wait=0, rom_addr=0, rom_data=0, cksum=0, byte count=0, pending=0, state=IDLE.
- Reset mid-operation discards any pending write; no rom_we is issued.
- States:
  - IDLE: core_reset=1. A rising edge of ioctl_download goes to LOAD.
  - LOAD: on entry clears count, error, done and cksum.
  - DRAIN: entered when ioctl_download falls. Waits for pending=0, then performs the end checks and goes to HOLD.
  - HOLD: counts HOLD_CYCLES with core_reset=1, then goes to DONE.
  - DONE: core_reset=0, dl_done=1.
- A rising edge of ioctl_download in HOLD or DONE returns to LOAD. core_reset=1 and dl_done=0 from the next cycle.
- Edges are detected against a registered copy of ioctl_download.
- Write path (LOAD only):
  - An ioctl_wr captures addr and data into the pending register and increments the byte count.
  - If tgt_busy=0 in the cycle after capture, rom_we pulses that cycle. Latency is 1 cycle from ioctl_wr to rom_we.
  - Otherwise ioctl_wait=1 (registered) from the cycle after capture until the cycle rom_we issues. rom_we fires in the first cycle with tgt_busy=0, exactly once.
  - rom_addr and rom_data remain valid while rom_we=1.
- Region decode (combinational on the captured address): region i when REG_BASE[i] <= addr < REG_BASE[i]+REG_SIZE[i]; offset = addr-REG_BASE[i], truncated to OFS_W.
- Address >= TOTAL_SIZE: no rom_we, dl_error set, byte still counted.
- ioctl_wr arriving while pending=1 is a protocol violation: the byte is dropped and dl_error is set.
- ioctl_wr outside LOAD is ignored.
- End checks on DRAIN exit: byte count != TOTAL_SIZE sets dl_error. A zero-length download sets dl_error.
- The byte count is 17 bits and saturates; no wrap.

Optional Feature:
- Macro ROM_CKSUM_EN.
- When defined: cksum accumulates each accepted in-range byte, modulo 2^16. At DRAIN exit, cksum != CKSUM_EXPECT sets dl_error. cksum holds its value until the next LOAD.
- When undefined: no accumulator, cksum=0, checksum does not affect dl_error.

Decomposition:
- Package rom_dl_pkg holds:
  - N_REGIONS=4.
  - REG_BASE and REG_SIZE arrays:
    - CPU: 0x0000, size 0x6000.
    - SND: 0x6000, size 0x1000.
    - CHR: 0x7000, size 0x2000.
    - SPR: 0x9000, size 0x4000.
  - TOTAL_SIZE=0xD000.
  - State enum: IDLE, LOAD, DRAIN, HOLD, DONE.
- One sub-module, rom_region_decode: purely combinational, maps address to one-hot hit, offset and out-of-range flag.

Test Plan:
- Region write: start download; ioctl_wr addr 0x6005 data 0xA5 with tgt_busy=0. Expect rom_we=4'b0010, rom_addr=0x0005, rom_data=0xA5 for exactly one cycle, one cycle later.
- Stall: same write with tgt_busy=1 for 3 cycles. Expect ioctl_wait=1 for 3 cycles and a single rom_we in the first tgt_busy=0 cycle.
- Full download: 0xD000 sequential bytes, then ioctl_download falls. Expect core_reset=1 for 16 cycles after drain, then core_reset=0, dl_done=1, dl_error=0. Each region receives offsets 0..REG_SIZE-1.
- Errors:
  - Write to 0xD000: expect no rom_we and dl_error=1.
  - Separate run with a 0x100-byte download: expect dl_error=1 and dl_done=1.
- Reset_n pulled low mid-LOAD with a pending write under tgt_busy=1: expect all reset values next cycle, no rom_we, state IDLE.
- With ROM_CKSUM_EN, CKSUM_EXPECT=16'h1234: download bytes summing to 0x1234 gives dl_error=0. Changing one byte by +1 gives cksum=0x1235 and dl_error=1.
